// File: rtl/handshake_sender_if.sv
// handshake_sender_if
//   Producer-side write port and peripheral-side send/ack handshake of
//   handshake_sender, grouped in one bundle.
//   master : the sender itself (takes wr_en/wr_data/ack/clr_err,
//            drives full/count/send/dataP/busy/done/timeout_err).
//   slave  : the environment around the sender (producer + peripheral).
interface handshake_sender_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic [CW-1:0]    count;
    logic             send;
    logic [WIDTH-1:0] dataP;
    logic             ack;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic             clr_err;

    modport master (
        input  wr_en, wr_data, ack, clr_err,
        output full, count, send, dataP, busy, done, timeout_err
    );

    modport slave (
        output wr_en, wr_data, ack, clr_err,
        input  full, count, send, dataP, busy, done, timeout_err
    );
endinterface

// File: rtl/handshake_sender.sv
// handshake_sender
//   Buffers producer words in a DEPTH-entry FIFO and hands them one at a
//   time to a peripheral over a four-phase send/ack handshake. A transfer
//   whose ack does not arrive within TIMEOUT cycles is dropped and the
//   sticky timeout_err flag is raised (TIMEOUT = 0 waits forever).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : handshake_sender_if.master
//         wr_en/wr_data -> FIFO write, full/count -> FIFO status,
//         send/dataP -> peripheral request/data, ack <- peripheral outack,
//         busy/done/timeout_err -> status, clr_err -> clears timeout_err
module handshake_sender #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    handshake_sender_if.master   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [TW-1:0]    timer;
    logic             send_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] data_q;
    logic             full;
    logic             push;
    logic             pop;

    assign full = (count == CW'(DEPTH));
    // A write while full is refused even if the FSM pops on the same edge.
    assign push = bus.wr_en && !full;
    assign pop  = (state == IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            send_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            timer  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.clr_err) begin
                err_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_q <= mem[rd_ptr];
                        send_q <= 1'b1;
                        timer  <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (bus.ack) begin
                        send_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= RELEASE;
                    end else if (TIMEOUT != 0 && timer == TW'(TIMEOUT - 1)) begin
                        // This ack-less edge would bring the timer to TIMEOUT:
                        // send has been high for TIMEOUT cycles, drop the word.
                        // Written after the clear so a same-edge set wins.
                        err_q  <= 1'b1;
                        send_q <= 1'b0;
                        state  <= RELEASE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!bus.ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full        = full;
    assign bus.count       = count;
    assign bus.send        = send_q;
    assign bus.dataP       = data_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
endmodule
